// File: rtl/mcs_pkg.sv
// mcs_pkg: definitions shared by the MCS RAM bank files.
//   phase_e    - the eight clock phases of one CPU instruction cycle
//   OPA_*      - low-nibble I/O instruction codes decoded by the bank
//   idx_below  - unsigned index bound check against an int parameter
package mcs_pkg;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    localparam logic [3:0] OPA_WRM = 4'h0;
    localparam logic [3:0] OPA_WMP = 4'h1;
    localparam logic [3:0] OPA_WR0 = 4'h4;  // WR0..WR3 share the upper bits 01
    localparam logic [3:0] OPA_SBM = 4'h8;
    localparam logic [3:0] OPA_RDM = 4'h9;
    localparam logic [3:0] OPA_ADM = 4'hB;
    localparam logic [3:0] OPA_RD0 = 4'hC;  // RD0..RD3 share the upper bits 11

    function automatic logic idx_below(input logic [3:0] idx, input int limit);
        return int'(idx) < limit;
    endfunction

endpackage

// File: rtl/mcs_phase_counter.sv
// mcs_phase_counter: tracks the instruction-cycle phase A1..X3.
//   clock - rising-edge clock
//   reset - synchronous active-high, forces A1
//   sync  - high during X3; forces A1 on the next clock from any phase
//   phase - current phase (also the state of this FSM)
module mcs_phase_counter
    import mcs_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   sync,
    output phase_e phase
);

    phase_e phase_q;
    phase_e phase_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= PH_A1;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = PH_A1;
        if (!sync && phase_q != PH_X3) begin
            phase_d = phase_e'(phase_q + 3'd1);
        end
    end

    always_comb begin
        phase = phase_q;
    end

endmodule

// File: rtl/mcs_ram_bank.sv
// mcs_ram_bank: one RAM chip of an MCS system; data memory, status
// characters and an output port addressed through SRC and I/O instructions.
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   sync, cm, data_in   - CPU bus: cycle marker, command line, nibble
//   data_out, data_oe   - registered read nibble and its bus-drive flag
//   out_port            - latched output port (PORT_W bits)
//   dbg_sel/reg/idx     - debug address (sel 0 = memory, 1 = status)
//   dbg_data            - debug read data, one clock after the address
//
// Bus handshake: there is no valid/ready; the phase counter decides when
// data_in is meaningful. cm in M2 marks an I/O instruction (opa latched),
// cm in X2 outside such a cycle marks SRC; reads are driven in X2 only.
module mcs_ram_bank
    import mcs_pkg::*;
#(
    parameter int CHIP_ID        = 0,
    parameter int NUM_REGS       = 4,
    parameter int STATUS_PER_REG = 4,
    parameter int PORT_W         = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sync,
    input  logic              cm,
    input  logic [3:0]        data_in,
    output logic [3:0]        data_out,
    output logic              data_oe,
    output logic [PORT_W-1:0] out_port,
    input  logic              dbg_sel,
    input  logic [1:0]        dbg_reg,
    input  logic [3:0]        dbg_idx,
    output logic [3:0]        dbg_data
);

    phase_e phase;

    mcs_phase_counter u_phase (
        .clock (clock),
        .reset (reset),
        .sync  (sync),
        .phase (phase)
    );

    logic              selected_q, selected_d;
    logic [1:0]        reg_ptr_q, reg_ptr_d;
    logic [3:0]        char_ptr_q, char_ptr_d;
    logic [3:0]        opa_q, opa_d;
    logic              io_pending_q, io_pending_d;
    logic              src_hit_q, src_hit_d;   // X2 of this cycle selected us
    logic [3:0]        data_out_q, data_out_d;
    logic              data_oe_q, data_oe_d;
    logic [3:0]        dbg_data_q, dbg_data_d;
    logic [PORT_W-1:0] out_port_q;

    // Full 4x16 / 4x4 arrays; unimplemented entries are never written and
    // never read back, so they stay at their reset value of zero.
    logic [3:0] mem_q    [4][16];
    logic [3:0] status_q [4][4];

    logic io_ok;
    logic stat_ok;
    logic exec_wr;

    // A sync that lands before X3 aborts the cycle, so it also blocks the
    // read setup in X1 and the write in X2 of that same clock.
    assign io_ok   = io_pending_q && selected_q && !sync
                     && idx_below({2'b00, reg_ptr_q}, NUM_REGS);
    assign stat_ok = idx_below({2'b00, opa_q[1:0]}, STATUS_PER_REG);
    assign exec_wr = (phase == PH_X2) && io_ok;

    always_comb begin
        selected_d   = selected_q;
        reg_ptr_d    = reg_ptr_q;
        char_ptr_d   = char_ptr_q;
        opa_d        = opa_q;
        io_pending_d = io_pending_q;
        src_hit_d    = 1'b0;
        // cm in X2 of an I/O cycle belongs to the I/O transfer, not SRC.
        if (phase == PH_X2 && cm && !io_pending_q) begin
            selected_d = (data_in[3:2] == 2'(CHIP_ID));
            reg_ptr_d  = data_in[1:0];
            src_hit_d  = (data_in[3:2] == 2'(CHIP_ID));
        end
        if (phase == PH_X3 && src_hit_q) begin
            char_ptr_d = data_in;
        end
        if (phase == PH_M2 && cm) begin
            opa_d        = data_in;
            io_pending_d = 1'b1;
        end
        if (phase == PH_X3 || sync) begin
            io_pending_d = 1'b0;
        end
    end

    // Read data is prepared in X1 so the registered bus drive lands in X2.
    always_comb begin
        data_out_d = 4'h0;
        data_oe_d  = 1'b0;
        if (phase == PH_X1 && io_ok) begin
            if (opa_q == OPA_SBM || opa_q == OPA_RDM || opa_q == OPA_ADM) begin
                data_oe_d  = 1'b1;
                data_out_d = mem_q[reg_ptr_q][char_ptr_q];
            end else if (opa_q[3:2] == OPA_RD0[3:2]) begin
                data_oe_d  = 1'b1;
                data_out_d = stat_ok ? status_q[reg_ptr_q][opa_q[1:0]] : 4'h0;
            end
        end
    end

    always_comb begin
        dbg_data_d = 4'h0;
        if (idx_below({2'b00, dbg_reg}, NUM_REGS)) begin
            if (!dbg_sel) begin
                dbg_data_d = mem_q[dbg_reg][dbg_idx];
            end else if (idx_below(dbg_idx, STATUS_PER_REG)) begin
                dbg_data_d = status_q[dbg_reg][dbg_idx[1:0]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            selected_q   <= 1'b0;
            reg_ptr_q    <= 2'd0;
            char_ptr_q   <= 4'd0;
            opa_q        <= 4'd0;
            io_pending_q <= 1'b0;
            src_hit_q    <= 1'b0;
            data_out_q   <= 4'd0;
            data_oe_q    <= 1'b0;
            dbg_data_q   <= 4'd0;
        end else begin
            selected_q   <= selected_d;
            reg_ptr_q    <= reg_ptr_d;
            char_ptr_q   <= char_ptr_d;
            opa_q        <= opa_d;
            io_pending_q <= io_pending_d;
            src_hit_q    <= src_hit_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            dbg_data_q   <= dbg_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_port_q <= '0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 16; c++) begin
                    mem_q[r][c] <= 4'd0;
                end
                for (int s = 0; s < 4; s++) begin
                    status_q[r][s] <= 4'd0;
                end
            end
        end else if (exec_wr) begin
            if (opa_q == OPA_WRM) begin
                mem_q[reg_ptr_q][char_ptr_q] <= data_in;
            end else if (opa_q == OPA_WMP) begin
                out_port_q <= data_in[PORT_W-1:0];
            end else if (opa_q[3:2] == OPA_WR0[3:2] && stat_ok) begin
                status_q[reg_ptr_q][opa_q[1:0]] <= data_in;
            end
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign out_port = out_port_q;
    assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_mcs_ram_bank.sv
// Bench for mcs_ram_bank with a chip that implements 3 registers, 2 status
// characters per register and a 2-bit output port, so the unimplemented
// register / status / port-bit boundaries are all reachable.
module tb_mcs_ram_bank;

    localparam int CHIP  = 0;
    localparam int NREG  = 3;
    localparam int NSTAT = 2;
    localparam int PW    = 2;

    logic          clock = 1'b0;
    logic          reset, sync, cm;
    logic [3:0]    data_in, data_out;
    logic          data_oe;
    logic [PW-1:0] out_port;
    logic          dbg_sel;
    logic [1:0]    dbg_reg;
    logic [3:0]    dbg_idx, dbg_data;

    int checks = 0;
    int errors = 0;
    int ph_tb  = 0;  // bench's own view of the phase, 0 = A1 ... 7 = X3

    // Reference model: architectural state only.
    logic [3:0]    mem_m  [4][16];
    logic [3:0]    stat_m [4][4];
    logic [PW-1:0] out_m;
    bit            sel_m;
    int            reg_m;
    int            char_m;
    logic [3:0]    exp_q[$];

    mcs_ram_bank #(
        .CHIP_ID(CHIP), .NUM_REGS(NREG), .STATUS_PER_REG(NSTAT), .PORT_W(PW)
    ) dut (
        .clock(clock), .reset(reset), .sync(sync), .cm(cm), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .out_port(out_port),
        .dbg_sel(dbg_sel), .dbg_reg(dbg_reg), .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    always #5 clock = ~clock;

    // ---------------- model ----------------
    task automatic model_clear();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) mem_m[r][c] = 4'h0;
            for (int s = 0; s < 4; s++) stat_m[r][s] = 4'h0;
        end
        out_m = '0; sel_m = 0; reg_m = 0; char_m = 0;
    endtask

    task automatic model_src(input logic [3:0] x2d, input logic [3:0] x3d);
        sel_m = (int'(x2d) / 4 == CHIP);
        reg_m = int'(x2d) % 4;
        if (sel_m) char_m = int'(x3d);
    endtask

    task automatic model_io(input logic [3:0] opa, input logic [3:0] d,
                            output bit exp_oe, output logic [3:0] exp_rd);
        int o;
        o = int'(opa);
        exp_oe = 0;
        exp_rd = 4'h0;
        if (sel_m && reg_m < NREG) begin
            if (o == 0) mem_m[reg_m][char_m] = d;
            else if (o == 1) out_m = d[PW-1:0];
            else if (o >= 4 && o <= 7) begin
                if (o - 4 < NSTAT) stat_m[reg_m][o-4] = d;
            end else if (o == 8 || o == 9 || o == 11) begin
                exp_oe = 1; exp_rd = mem_m[reg_m][char_m];
            end else if (o >= 12) begin
                exp_oe = 1; exp_rd = (o - 12 < NSTAT) ? stat_m[reg_m][o-12] : 4'h0;
            end
        end
    endtask

    function automatic logic [3:0] model_dbg(input int s, input int r, input int i);
        if (r >= NREG) return 4'h0;
        if (s == 1) return (i < NSTAT) ? stat_m[r][i] : 4'h0;
        return mem_m[r][i];
    endfunction

    // ---------------- drivers ----------------
    task automatic tick(input logic s, input logic c, input logic r, input logic [3:0] d);
        reset = r; sync = s; cm = c; data_in = d;
        @(posedge clock);
        #1;
        if (r || s) ph_tb = 0;
        else ph_tb = (ph_tb + 1) % 8;
        reset = 1'b0;
    endtask

    task automatic idle_tick();
        tick(ph_tb == 7, 1'b0, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    task automatic dbg_read(input logic s, input logic [1:0] r, input logic [3:0] i,
                            output logic [3:0] d);
        dbg_sel = s; dbg_reg = r; dbg_idx = i;
        idle_tick();
        d = dbg_data;
    endtask

    // One instruction cycle. oe_mask bit p = data_oe seen during phase p;
    // sync_at / rst_at (or -1) cut the cycle short at that phase.
    task automatic bus_cycle(input logic cm_m2, input logic [3:0] m2d,
                             input logic cm_x2, input logic [3:0] x2d,
                             input logic [3:0] x3d, input int sync_at, input int rst_at,
                             output logic [7:0] oe_mask, output logic [3:0] rd);
        logic s, c, r;
        logic [3:0] d;
        while (ph_tb != 0) idle_tick();
        oe_mask = 8'h00;
        rd = 4'h0;
        for (int p = 0; p < 8; p++) begin
            oe_mask[p] = data_oe;
            if (data_oe) rd = data_out;
            d = 4'($urandom_range(0, 15));
            c = 1'b0;
            s = (p == 7) || (p == sync_at);
            r = (p == rst_at);
            if (p == 4) begin c = cm_m2; d = m2d; end
            if (p == 6) begin c = cm_x2; d = x2d; end
            if (p == 7) d = x3d;
            tick(s, c, r, d);
            if (s || r) break;
        end
    endtask

    task automatic do_src(input logic [3:0] x2d, input logic [3:0] x3d);
        logic [7:0] m;
        logic [3:0] rd;
        bus_cycle(1'b0, 4'h0, 1'b1, x2d, x3d, -1, -1, m, rd);
        model_src(x2d, x3d);
    endtask

    task automatic do_io(input logic [3:0] opa, input logic [3:0] d,
                         output logic [7:0] m, output logic [3:0] rd);
        bus_cycle(1'b1, opa, 1'b0, d, 4'($urandom_range(0, 15)), -1, -1, m, rd);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0] got;
        tick(1'b0, 1'b0, 1'b1, 4'h0);
        tick(1'b0, 1'b0, 1'b1, 4'h0);
        model_clear();
        checks++;
        if (data_oe !== 1'b0 || data_out !== 4'h0 || out_port !== '0) begin
            errors++;
            $display("FAIL reset_outputs: oe=%b out=%h port=%h required 0/0/0", data_oe, data_out, out_port);
        end
        for (int s = 0; s < 2; s++) for (int r = 0; r < 4; r++) for (int i = 0; i < 16; i++) begin
            dbg_read(s[0], r[1:0], i[3:0], got);
            checks++;
            if (got !== 4'h0) begin
                errors++;
                $display("FAIL reset_dbg[%0d,%0d,%0d]: got %h required 0", s, r, i, got);
            end
        end
    endtask

    task automatic test_wrm_rdm();
        logic [7:0] m; logic [3:0] rd, got; bit eo; logic [3:0] er;
        do_src(4'h2, 4'h5);
        do_io(4'h0, 4'hA, m, rd); model_io(4'h0, 4'hA, eo, er);
        checks++;
        if (m !== 8'h00) begin errors++; $display("FAIL wrm_oe: mask %h required 00", m); end
        dbg_read(1'b0, 2'd2, 4'd5, got);
        checks++;
        if (got !== 4'hA) begin errors++; $display("FAIL wrm_dbg: got %h required a", got); end
        do_io(4'h9, 4'h0, m, rd); model_io(4'h9, 4'h0, eo, er);
        checks++;
        if (m !== 8'h40 || rd !== 4'hA) begin
            errors++; $display("FAIL rdm_read: mask %h data %h required 40 a", m, rd);
        end
    endtask

    task automatic test_unselected();
        logic [7:0] m; logic [3:0] rd, got; bit eo; logic [3:0] er;
        do_src(4'h4, 4'h0);
        do_io(4'h0, 4'h7, m, rd); model_io(4'h0, 4'h7, eo, er);
        checks++;
        if (m !== 8'h00) begin errors++; $display("FAIL unsel_wrm_oe: mask %h required 00", m); end
        dbg_read(1'b0, 2'd0, 4'd0, got);
        checks++;
        if (got !== 4'h0) begin errors++; $display("FAIL unsel_mem: got %h required 0", got); end
        do_io(4'h9, 4'h0, m, rd); model_io(4'h9, 4'h0, eo, er);
        checks++;
        if (m !== 8'h00) begin errors++; $display("FAIL unsel_rdm_oe: mask %h required 00", m); end
    endtask

    task automatic test_status();
        logic [7:0] m; logic [3:0] rd, got; bit eo; logic [3:0] er;
        do_src(4'h1, 4'h0);
        do_io(4'h7, 4'h9, m, rd); model_io(4'h7, 4'h9, eo, er);
        dbg_read(1'b1, 2'd1, 4'd3, got);
        checks++;
        if (got !== 4'h0) begin errors++; $display("FAIL wr3_ignored: got %h required 0", got); end
        do_io(4'hF, 4'h0, m, rd); model_io(4'hF, 4'h0, eo, er);
        checks++;
        if (m !== 8'h40 || rd !== 4'h0) begin
            errors++; $display("FAIL rd3_zero: mask %h data %h required 40 0", m, rd);
        end
        do_io(4'h5, 4'h9, m, rd); model_io(4'h5, 4'h9, eo, er);
        do_io(4'hD, 4'h0, m, rd); model_io(4'hD, 4'h0, eo, er);
        checks++;
        if (m !== 8'h40 || rd !== 4'h9) begin
            errors++; $display("FAIL rd1_read: mask %h data %h required 40 9", m, rd);
        end
        do_io(4'hA, 4'h0, m, rd); model_io(4'hA, 4'h0, eo, er);
        checks++;
        if (m !== 8'h00) begin errors++; $display("FAIL opa_a_ignored: mask %h required 00", m); end
    endtask

    task automatic test_src_precedence();
        logic [7:0] m; logic [3:0] rd; bit eo; logic [3:0] er;
        do_src(4'h2, 4'h6);
        // cm in X2 of a WRM whose data would select chip 1 if taken as SRC
        bus_cycle(1'b1, 4'h0, 1'b1, 4'h4, 4'h0, -1, -1, m, rd);
        model_io(4'h0, 4'h4, eo, er);
        do_io(4'h9, 4'h0, m, rd); model_io(4'h9, 4'h0, eo, er);
        checks++;
        if (m !== 8'h40 || rd !== 4'h4) begin
            errors++; $display("FAIL io_over_src: mask %h data %h required 40 4", m, rd);
        end
    endtask

    task automatic test_sync_abort();
        logic [7:0] m; logic [3:0] rd, got; bit eo; logic [3:0] er;
        do_src(4'h0, 4'h7);
        bus_cycle(1'b1, 4'h0, 1'b0, 4'hC, 4'h0, 3, -1, m, rd);
        bus_cycle(1'b1, 4'h0, 1'b0, 4'hC, 4'h0, 5, -1, m, rd);
        dbg_read(1'b0, 2'd0, 4'd7, got);
        checks++;
        if (got !== 4'h0) begin errors++; $display("FAIL abort_no_write: got %h required 0", got); end
        bus_cycle(1'b1, 4'h9, 1'b0, 4'h0, 4'h0, 5, -1, m, rd);
        checks++;
        if (data_oe !== 1'b0) begin errors++; $display("FAIL abort_no_read: oe %b required 0", data_oe); end
        do_io(4'h0, 4'h3, m, rd); model_io(4'h0, 4'h3, eo, er);
        dbg_read(1'b0, 2'd0, 4'd7, got);
        checks++;
        if (got !== 4'h3) begin errors++; $display("FAIL write_after_abort: got %h required 3", got); end
    endtask

    task automatic test_port_and_reset();
        logic [7:0] m; logic [3:0] rd, got; bit eo; logic [3:0] er;
        do_src(4'h0, 4'h0);
        do_io(4'h1, 4'hF, m, rd); model_io(4'h1, 4'hF, eo, er);
        checks++;
        if (out_port !== 2'b11) begin errors++; $display("FAIL wmp_port: got %b required 11", out_port); end
        do_io(4'h1, 4'h6, m, rd); model_io(4'h1, 4'h6, eo, er);
        checks++;
        if (out_port !== out_m) begin errors++; $display("FAIL wmp_low_bits: got %b required %b", out_port, out_m); end
        tick(1'b0, 1'b0, 1'b1, 4'h0);
        model_clear();
        checks++;
        if (out_port !== '0) begin errors++; $display("FAIL port_reset: got %b required 0", out_port); end
        for (int s = 0; s < 2; s++) for (int r = 0; r < 4; r++) for (int i = 0; i < 16; i++) begin
            dbg_read(s[0], r[1:0], i[3:0], got);
            checks++;
            if (got !== 4'h0) begin
                errors++; $display("FAIL cleared_dbg[%0d,%0d,%0d]: got %h required 0", s, r, i, got);
            end
        end
    endtask

    task automatic test_reset_in_x2();
        logic [7:0] m; logic [3:0] rd, got;
        do_src(4'h1, 4'h4);
        bus_cycle(1'b1, 4'h0, 1'b0, 4'h6, 4'h0, -1, 6, m, rd);
        model_clear();
        checks++;
        if (data_oe !== 1'b0) begin errors++; $display("FAIL rst_x2_oe: oe %b required 0", data_oe); end
        dbg_read(1'b0, 2'd1, 4'd4, got);
        checks++;
        if (got !== 4'h0) begin errors++; $display("FAIL rst_x2_mem: got %h required 0", got); end
    endtask

    task automatic test_random();
        logic [7:0] m; logic [3:0] rd, got, opa, d, er; bit eo;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) d[3:2] = 2'(CHIP);
                do_src(d, 4'($urandom_range(0, 15)));
            end else begin
                opa = 4'($urandom_range(0, 15));
                d = 4'($urandom_range(0, 15));
                do_io(opa, d, m, rd);
                model_io(opa, d, eo, er);
                if (eo) exp_q.push_back(er);
                checks++;
                if (m !== (eo ? 8'h40 : 8'h00)) begin
                    errors++; $display("FAIL rand_oe[%0d] opa %h: mask %h required %h", n, opa, m, eo ? 8'h40 : 8'h00);
                end
                if (eo && exp_q.size() > 0) begin
                    er = exp_q.pop_front();
                    checks++;
                    if (rd !== er) begin errors++; $display("FAIL rand_rd[%0d] opa %h: got %h required %h", n, opa, rd, er); end
                end
                checks++;
                if (out_port !== out_m) begin errors++; $display("FAIL rand_port[%0d]: got %b required %b", n, out_port, out_m); end
            end
        end
        for (int s = 0; s < 2; s++) for (int r = 0; r < 4; r++) for (int i = 0; i < 16; i++) begin
            dbg_read(s[0], r[1:0], i[3:0], got);
            checks++;
            if (got !== model_dbg(s, r, i)) begin
                errors++; $display("FAIL rand_dbg[%0d,%0d,%0d]: got %h required %h", s, r, i, got, model_dbg(s, r, i));
            end
        end
    endtask

    initial begin
        reset = 1'b1; sync = 1'b0; cm = 1'b0; data_in = 4'h0;
        dbg_sel = 1'b0; dbg_reg = 2'd0; dbg_idx = 4'd0;
        test_reset();
        test_wrm_rdm();
        test_unselected();
        test_status();
        test_src_precedence();
        test_sync_abort();
        test_port_and_reset();
        test_reset_in_x2();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
